// File: rtl/stack_unit.sv
// Operand stack for the single-cycle stack CPU: moves sp by the decoded delta
// and optionally writes the selected datapath value into the new top.
module stack_unit #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16,
   parameter int SPW   = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [1:0]       StackUpdateMode,
   input  logic [1:0]       StackWriteSrc,
   input  logic [WIDTH-1:0] ALUresult,
   input  logic [WIDTH-1:0] dmem_read,
   input  logic [WIDTH-1:0] PC_temp,
   output logic [WIDTH-1:0] tos,
   output logic [WIDTH-1:0] nos,
   output logic [SPW-1:0]   sp,
   output logic             empty,
   output logic             full,
   output logic             overflow,
   output logic             underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam logic signed [SPW:0] DEPTH_S = (SPW+1)'(DEPTH);

   logic [WIDTH-1:0]      mem [DEPTH];
   logic signed [SPW:0]   delta;
   logic signed [SPW:0]   nsp;
   logic                  wr_req;
   logic                  too_high;
   logic                  too_low;
   logic                  wr_zero;
   logic                  legal;
   logic [AW-1:0]         wr_idx;
   logic [AW-1:0]         tos_idx;
   logic [AW-1:0]         nos_idx;
   logic [WIDTH-1:0]      wr_data;

   always_comb begin
      delta = '0;
      case (StackUpdateMode)
         2'b00:   delta = '0;
         2'b01:   delta = (SPW+1)'(1);
         2'b10:   delta = -(SPW+1)'(2);
         default: delta = -(SPW+1)'(1);
      endcase
   end

   // One extra sign bit so pops below zero show up as negative nsp.
   assign nsp      = $signed({1'b0, sp}) + delta;
   assign wr_req   = (StackWriteSrc != 2'b00);
   assign too_high = (nsp > DEPTH_S);
   assign too_low  = nsp[SPW];
   assign wr_zero  = wr_req && (nsp == '0);
   assign legal    = !too_high && !too_low && !wr_zero;

   // Slot indices wrap modulo DEPTH; sp==DEPTH maps its top to DEPTH-1.
   assign wr_idx  = nsp[AW-1:0] - AW'(1);
   assign tos_idx = sp[AW-1:0] - AW'(1);
   assign nos_idx = sp[AW-1:0] - AW'(2);

   always_comb begin
      wr_data = '0;
      case (StackWriteSrc)
         2'b01:   wr_data = ALUresult;
         2'b10:   wr_data = dmem_read;
         2'b11:   wr_data = PC_temp;
         default: wr_data = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sp        <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (en) begin
         if (legal) begin
            sp <= nsp[SPW-1:0];
         end
         if (too_high) begin
            overflow <= 1'b1;
         end
         if (too_low || wr_zero) begin
            underflow <= 1'b1;
         end
      end
   end

   // Array is never cleared; stale entries above sp are unobservable.
   always_ff @(posedge clk) begin
      if (!reset && en && legal && wr_req) begin
         mem[wr_idx] <= wr_data;
      end
   end

   assign tos   = (sp != '0)        ? mem[tos_idx] : '0;
   assign nos   = (sp >= SPW'(2))   ? mem[nos_idx] : '0;
   assign empty = (sp == '0);
   assign full  = (sp == SPW'(DEPTH));

endmodule

// File: tb/tb_stack_unit.sv
// Randomized and directed checks of stack_unit against a queue-free array model.
module tb_stack_unit;

   localparam int WIDTH = 32;
   localparam int DEPTH = 16;
   localparam int SPW   = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             en;
   logic [1:0]       mode;
   logic [1:0]       src;
   logic [WIDTH-1:0] alu_v;
   logic [WIDTH-1:0] dmem_v;
   logic [WIDTH-1:0] pc_v;
   logic [WIDTH-1:0] tos;
   logic [WIDTH-1:0] nos;
   logic [SPW-1:0]   sp;
   logic             empty;
   logic             full;
   logic             overflow;
   logic             underflow;

   int vectors = 0;
   int errors  = 0;
   bit chk_en  = 1'b0;

   // Reference model state
   int               m_sp;
   logic [WIDTH-1:0] m_mem [DEPTH];
   bit               m_ovf;
   bit               m_unf;

   stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SPW(SPW)) dut (
      .clk(clk),
      .reset(reset),
      .en(en),
      .StackUpdateMode(mode),
      .StackWriteSrc(src),
      .ALUresult(alu_v),
      .dmem_read(dmem_v),
      .PC_temp(pc_v),
      .tos(tos),
      .nos(nos),
      .sp(sp),
      .empty(empty),
      .full(full),
      .overflow(overflow),
      .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [WIDTH-1:0] m_tos();
      return (m_sp >= 1) ? m_mem[m_sp-1] : '0;
   endfunction

   function automatic logic [WIDTH-1:0] m_nos();
      return (m_sp >= 2) ? m_mem[m_sp-2] : '0;
   endfunction

   // Compare process: every falling edge once the bench has applied reset.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("sp",        WIDTH'(sp),        WIDTH'(m_sp));
         chk("tos",       tos,               m_tos());
         chk("nos",       nos,               m_nos());
         chk("empty",     WIDTH'(empty),     WIDTH'(m_sp == 0));
         chk("full",      WIDTH'(full),      WIDTH'(m_sp == DEPTH));
         chk("overflow",  WIDTH'(overflow),  WIDTH'(m_ovf));
         chk("underflow", WIDTH'(underflow), WIDTH'(m_unf));
      end
   end

   // Apply one cycle of inputs, advance the model at the edge, return at negedge.
   task automatic step(input bit r, input bit e, input logic [1:0] m, input logic [1:0] s,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] p);
      int nsp;
      int dl;
      logic [WIDTH-1:0] val;
      reset = r; en = e; mode = m; src = s; alu_v = a; dmem_v = d; pc_v = p;
      @(posedge clk);
      if (r) begin
         m_sp = 0; m_ovf = 0; m_unf = 0;
      end else if (e) begin
         dl  = (m == 2'd0) ? 0 : (m == 2'd1) ? 1 : (m == 2'd2) ? -2 : -1;
         nsp = m_sp + dl;
         val = (s == 2'd1) ? a : (s == 2'd2) ? d : p;
         if (nsp > DEPTH) m_ovf = 1;
         else if (nsp < 0 || (s != 2'd0 && nsp == 0)) m_unf = 1;
         else begin
            if (s != 2'd0) m_mem[nsp-1] = val;
            m_sp = nsp;
         end
      end
      @(negedge clk);
   endtask

   task automatic push(input logic [WIDTH-1:0] d);
      step(0, 1, 2'b01, 2'b10, '0, d, '0);
   endtask

   task automatic do_reset();
      step(1, 1, 2'b01, 2'b10, '0, 32'hDEAD_BEEF, '0);
   endtask

   initial begin
      bit r, e;
      int u;
      logic [1:0] m;
      m_sp = 0; m_ovf = 0; m_unf = 0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      reset = 1'b1; en = 1'b0; mode = '0; src = '0; alu_v = '0; dmem_v = '0; pc_v = '0;
      @(negedge clk);
      do_reset();
      chk_en = 1'b1;
      chk("rst_sp", WIDTH'(sp), 0);
      chk("rst_empty", WIDTH'(empty), 1);
      chk("rst_tos", tos, 0);

      push(32'h11); push(32'h22); push(32'h33);
      chk("push3_sp", WIDTH'(sp), 3);
      chk("push3_tos", tos, 32'h33);
      chk("push3_nos", nos, 32'h22);

      step(0, 1, 2'b11, 2'b01, 32'h55, '0, '0);
      chk("add_sp", WIDTH'(sp), 2);
      chk("add_tos", tos, 32'h55);
      chk("add_nos", nos, 32'h11);
      step(0, 1, 2'b00, 2'b01, 32'hFFFF_FFAB, '0, '0);
      chk("neg_tos", tos, 32'hFFFF_FFAB);
      chk("neg_sp", WIDTH'(sp), 2);

      step(0, 1, 2'b01, 2'b11, '0, '0, 32'h40);
      chk("pushpc_tos", tos, 32'h40);
      step(0, 1, 2'b11, 2'b00, '0, '0, '0);
      chk("poppc_sp", WIDTH'(sp), 2);

      do_reset();
      for (int i = 0; i < DEPTH; i++) push(32'h100 + i);
      chk("fill_full", WIDTH'(full), 1);
      push(32'hBAD);
      chk("ovf_flag", WIDTH'(overflow), 1);
      chk("ovf_sp", WIDTH'(sp), 16);
      chk("ovf_tos", tos, 32'h10F);
      step(0, 1, 2'b11, 2'b00, '0, '0, '0);
      chk("ovf_pop_sp", WIDTH'(sp), 15);
      chk("ovf_sticky", WIDTH'(overflow), 1);

      do_reset();
      push(32'h77);
      step(0, 1, 2'b10, 2'b00, '0, '0, '0);
      chk("unf_flag", WIDTH'(underflow), 1);
      chk("unf_sp", WIDTH'(sp), 1);
      do_reset();
      step(0, 1, 2'b00, 2'b01, 32'h99, '0, '0);
      chk("unf0_flag", WIDTH'(underflow), 1);
      chk("unf0_sp", WIDTH'(sp), 0);
      chk("unf0_tos", tos, 0);

      do_reset();
      push(32'hA1);
      step(0, 0, 2'b01, 2'b10, '0, 32'hEE, '0);
      chk("halt_sp", WIDTH'(sp), 1);
      chk("halt_tos", tos, 32'hA1);
      for (int i = 0; i < 4; i++) push(32'hC0 + i);
      chk("pre_rst_sp", WIDTH'(sp), 5);
      do_reset();
      chk("mid_rst_sp", WIDTH'(sp), 0);
      chk("mid_rst_tos", tos, 0);
      chk("mid_rst_ovf", WIDTH'(overflow | underflow), 0);

      for (int i = 0; i < 800; i++) begin
         r = ($urandom_range(0, 99) < 2);
         e = ($urandom_range(0, 9) != 0);
         u = $urandom_range(0, 9);
         m = (u < 4) ? 2'b01 : (u < 6) ? 2'b00 : (u < 8) ? 2'b11 : (u == 8) ? 2'b10 : 2'($urandom_range(0, 3));
         step(r, e, m, 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom);
      end

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/stack_unit.md
# stack_unit

Operand stack of the single-cycle stack CPU: the consumer of the decoder's `StackUpdateMode` and `StackWriteSrc` control fields. Each enabled clock it moves the stack pointer by the decoded delta and, when asked, writes the selected datapath value (ALU result, data-memory read, or return PC) into the new top-of-stack. It presents top and next-of-stack combinationally to the ALU and memory stages, and flags overflow/underflow instead of corrupting state.

## Interface
- `WIDTH`, 32, data width of each stack entry
- `DEPTH`, 16, number of entries (power of two, ≥ 4)
- `SPW`, $clog2(DEPTH)+1, stack-pointer width (must hold 0..DEPTH)

- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `en`  in  1  update enable; 0 = hold all state (halt)
- `StackUpdateMode`  in  2  00: sp, 01: sp+1, 10: sp-2, 11: sp-1
- `StackWriteSrc`  in  2  00: no write, 01: `ALUresult`, 10: `dmem_read`, 11: `PC_temp`
- `ALUresult`  in  WIDTH  ALU output
- `dmem_read`  in  WIDTH  data-memory read data
- `PC_temp`  in  WIDTH  PC+1 (return address for push_pc)
- `tos`  out  WIDTH  top of stack, mem[sp-1]; 0 when sp<1
- `nos`  out  WIDTH  next of stack, mem[sp-2]; 0 when sp<2
- `sp`  out  SPW  number of valid entries
- `empty`  out  1  sp == 0
- `full`  out  1  sp == DEPTH
- `overflow`  out  1  sticky: an update would exceed DEPTH
- `underflow`  out  1  sticky: an update would go below 0, or write with resulting sp==0

## Operation
- `sp` counts valid entries; slot sp-1 is top. Entries live in a DEPTH×WIDTH register array.
- Candidate next pointer: nsp = sp + delta, delta ∈ {0, +1, −2, −1} per `StackUpdateMode`, computed signed with one extra bit so negative results are detected.
- Legal update (en=1): nsp in 0..DEPTH, and if `StackWriteSrc`≠00 then nsp ≥ 1. On legal update: sp ← nsp; if write requested, mem[nsp−1] ← selected source.
- Illegal update: sp and array unchanged; nsp > DEPTH sets `overflow`; nsp < 0, or write with nsp==0, sets `underflow`. Flags stay set until reset; later legal updates still execute.
- Write target is always the new top, so: binary op (mode 11, src 01) overwrites old nos with result; unary op (mode 00, src 01) overwrites tos; push/load (mode 01, src 10 or 01) writes new slot; push_pc (mode 01, src 11); pop/branch (mode 11 or 10, src 00) discard only.
- en=0: no state change, no flag change; outputs still reflect current state.
- Entries above sp keep stale contents; never observable through `tos`/`nos`.

## Timing
- Reset (sync, `reset`=1 at edge): sp=0, overflow=0, underflow=0; therefore empty=1, full=0, tos=0, nos=0. Array contents not cleared. Reset wins over `en`.
- `tos`, `nos`, `empty`, `full` combinational from registered sp and array; zero-cycle read latency.
- Update latency one cycle: values written at edge N visible on `tos` after edge N (same-cycle read returns the pre-edge value; no bypass).
- Flags assert on the edge that rejects the update, visible after that edge.
- Reset asserted mid-program discards everything; first instruction after deassert sees an empty stack.

## Test plan
- Reset, then 3× push (mode 01, src 10) of 0x11, 0x22, 0x33 -> sp=3, tos=0x33, nos=0x22, flags 0.
- From that state, add (mode 11, src 01, ALUresult=0x55) -> sp=2, tos=0x55, nos=0x11; then neg (mode 00, src 01, 0xFFFFFFAB) -> sp=2, tos=0xFFFFFFAB.
- push_pc (mode 01, src 11, PC_temp=0x40) then pop_pc-style pop (mode 11, src 00) -> tos=0x40 after first, sp back to prior value after second.
- Fill to DEPTH=16 pushes -> full=1; 17th push -> overflow=1, sp=16, tos unchanged; following pop -> sp=15, overflow still 1.
- From sp=1, branch (mode 10, src 00) -> underflow=1, sp=1; from sp=0 unary write (mode 00, src 01) -> underflow, no write.
- en=0 with push request -> sp/tos unchanged; assert reset while sp=5 -> sp=0, tos=0, flags cleared next cycle.
